// File: rtl/iic_axil_pkg.sv
// Shared types and constants for the IIC AXI4-Lite command master.
package iic_axil_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // axi_iic register byte offsets.
  localparam logic [8:0] REG_SOFTR   = 9'h040;
  localparam logic [8:0] REG_CR      = 9'h100;
  localparam logic [8:0] REG_SR      = 9'h104;
  localparam logic [8:0] REG_TX_FIFO = 9'h108;
  localparam logic [8:0] REG_RX_FIFO = 9'h10C;

endpackage

// File: rtl/iic_axil_master_if.sv
// AXI4-Lite bus bundle between the command master and the axi_iic slave port.
interface iic_axil_master_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/iic_axil_master.sv
// Single-outstanding command-to-AXI4-Lite master for the axi_iic controller.
// Optional watchdog enabled by defining IIC_AXIL_MASTER_TIMEOUT_EN.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | cmd_ready high, waiting for a command
//   ST_WR      | AW and W valids up, each drops after its own handshake
//   ST_WR_RESP | bready high, waiting for bvalid
//   ST_RD_ADDR | arvalid high, waiting for arready
//   ST_RD_DATA | rready high, waiting for rvalid
//   ST_RSP     | rsp_valid high, payload held until rsp_ready
module iic_axil_master
  import iic_axil_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              s_axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  iic_axil_master_if.master m_axi
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;

  logic aw_hs;
  logic w_hs;

  assign aw_hs = awvalid_q & m_axi.awready;
  assign w_hs  = wvalid_q & m_axi.wready;

`ifdef IIC_AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             busy;
  logic             timeout_hit;

  assign busy        = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                       (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
  assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (m_axi.bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi.bresp;
          state_d     = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_axi.rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = m_axi.rresp;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef IIC_AXIL_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
    if ((state_q == ST_RSP) && rsp_ready) rsp_timeout_d = 1'b0;

    if (busy) cnt_d = cnt_q + CNT_W'(1);
    else if (state_q == ST_IDLE) cnt_d = '0;
    else cnt_d = cnt_q;

    // Abort overrides whatever the channel logic decided this cycle.
    if (timeout_hit) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = ST_RSP;
    end
`endif
  end

  // State and registered outputs; reset drops every valid/ready at once.
  always_ff @(posedge clk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
`ifdef IIC_AXIL_MASTER_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef IIC_AXIL_MASTER_TIMEOUT_EN
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

`ifdef IIC_AXIL_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = (state_q == ST_IDLE) && s_axi_aresetn;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: doc/iic_axil_master.md
Name: iic_axil_master

Overview:
- Command-to-AXI4-Lite master sequencer that sits directly upstream of the axi_iic_0 controller and drives its s_axi_* slave port.
- Accepts one register read or write command at a time from local control logic (bring-up FSM or scan harness).
- Performs the full AXI-Lite transaction, then returns read data and response on a held response port.
- Strictly one outstanding transaction; no pipelining across commands.

Parameters:
- ADDR_W, 9, AXI-Lite address width; matches the IIC register map.
- DATA_W, 32, AXI-Lite data width; only 32 is supported.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only when IIC_AXIL_MASTER_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- s_axi_aresetn  in  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is used as-is (synchronised externally).
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP.
- rsp_timeout  out  1  transaction aborted by the watchdog; tied 0 when the feature is absent.
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  standard AXI-Lite master signals, widths per parameters.

Behaviour:
- Reset values: all outputs 0, except that cmd_ready is 1 once out of reset (state IDLE). This covers every *valid, bready, rready, rsp_* and address/data register.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch addr, wdata and wstrb.
  - Go to WR if cmd_write, else RD_ADDR.
  - The next cycle drives the valids (registered outputs; one-cycle issue latency).
- WR:
  - awvalid and wvalid rise together.
  - Each drops in the cycle after its own handshake (valid&ready). They complete independently, in either order or simultaneously.
  - Leave WR when both handshakes are done.
  - bready is asserted in the same cycle as the last handshake completes, or the cycle after it.
- WR_RESP:
  - bready=1.
  - On bvalid, capture bresp, set rsp_rdata=0, go to RSP.
  - A bvalid that arrives before the AW/W handshakes finish is ignored until this state is reached. The slave is not allowed to send one, so this case is protocol-illegal.
- RD_ADDR:
  - arvalid=1 until arready.
  - Then go to RD_DATA with rready=1.
- RD_DATA:
  - On rvalid&rready, capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid=1; data is held stable until rsp_ready.
  - On rsp_ready, go to IDLE. cmd_ready rises the following cycle, so back-to-back commands are spaced by at least one IDLE cycle.
- Valid-hold rules:
  - Once any *valid is asserted, it and its payload stay stable until the handshake completes.
  - Valid never depends combinationally on ready.
- A cmd_valid that arrives while the block is busy is held off by cmd_ready=0. It is not dropped.
- Reset mid-transaction:
  - All valids and readies drop immediately (asynchronously), and the FSM returns to IDLE.
  - The slave is reset by the same signal, so no partial transaction survives.
- Minimum latency with a zero-wait slave:
  - Write: cmd accept to rsp_valid = 4 cycles.
  - Read: cmd accept to rsp_valid = 4 cycles.

Optional Feature:
- Macro: IIC_AXIL_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on leaving IDLE and increments every cycle outside IDLE and RSP.
  - When it reaches TIMEOUT_CYCLES, all AXI valids and readies drop and the FSM goes to RSP with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0.
  - rsp_timeout clears on the rsp_ready handshake.
- When undefined:
  - No counter exists, rsp_timeout is constant 0, and the block waits indefinitely.

Decomposition:
- Shared package iic_axil_pkg holds:
  - the FSM state enum;
  - AXI response constants (OKAY=2'b00, SLVERR=2'b10);
  - IIC register offset constants (CR=9'h100, SR=9'h104, TX_FIFO=9'h108, RX_FIFO=9'h10C, SOFTR=9'h040).
- No sub-module is needed. The optional watchdog lives inline under the macro.

Test Plan:
- Zero-wait write of addr 9'h100, data 32'h0000_0001, wstrb 4'hF -> AW/W asserted 1 cycle after accept; rsp_valid at cycle 4 with rsp_resp=0 and rsp_rdata=0.
- Write where wready lags awready by 3 cycles -> awvalid drops after its handshake, wvalid stays high with stable wdata, bready is asserted only after the W handshake, and exactly one response is returned.
- Read of 9'h104 with rvalid delayed 5 cycles and rdata 32'h0000_00C0, rresp 2'b00 -> rsp_rdata=32'hC0; rsp held for 3 cycles while rsp_ready=0, with no change.
- Slave returns bresp 2'b10 -> rsp_resp=2'b10; the next command is accepted normally.
- s_axi_aresetn pulsed low during RD_DATA -> arvalid and rready are 0 in the same cycle and cmd_ready=1 after release; no stale rsp_valid.
- With IIC_AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, awready held 0 -> after 16 cycles awvalid and wvalid drop and rsp_valid=1 with rsp_timeout=1, rsp_resp=2'b10.
